player_move_ctrl: RTL and testbench
===================================

// Module: player_move_ctrl
// PURPOSE
//  Sequences debounced A/B/C button presses into player moves: rotate -90 (A), forward (B), rotate +90 (C).
//  Owns player position and heading, and asks the map for a wall check before each forward step.
//  Requests one frame redraw per accepted move.
//  Sits between the board buttons and the map/renderer blocks.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button's level is accepted
//  COORD_W          4       width of pos_x/pos_y
//  MAP_W            16      legal x range 0..MAP_W-1
//  MAP_H            16      legal y range 0..MAP_H-1
//  START_X          1       reset x position
//  START_Y          1       reset y position
//  START_DIR        0       reset heading
//  REPEAT_CYCLES    2000000 forward auto-repeat period (MOVE_REPEAT_EN only)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous reset, active-high
//  A, B, C    in   1        raw buttons, asynchronous
//  chk_x      out  COORD_W  x of the cell to check
//  chk_y      out  COORD_W  y of the cell to check
//  chk_req    out  1        wall-check request
//  chk_ack    in   1        wall-check answer valid
//  chk_wall   in   1        1 = checked cell is a wall
//  pos_x      out  COORD_W  player x position
//  pos_y      out  COORD_W  player y position
//  dir        out  2        heading: 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
//  frame_req  out  1        redraw request
//  frame_ack  in   1        renderer has accepted the redraw
//  blocked    out  1        1-cycle pulse when a forward move is refused
//  busy       out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset:
//   - pos = (START_X, START_Y), dir = START_DIR, state = IDLE.
//   - chk_req, frame_req, blocked = 0; chk_x/chk_y = 0.
//   - All debouncers read released. Reset asserted mid-operation drops every request immediately.
//  Inputs:
//   - Each button passes a 2-flop synchronizer, then a debounce counter.
//   - The stable level changes only after DEBOUNCE_CYCLES consecutive cycles at the new value.
//  Decode of stable {A,B,C}:
//   - 100 = rotN90, 010 = fwd, 001 = rot90.
//   - Any 2 or 3 high = "multi": treated as a press but performs no action.
//  FSM:
//   - IDLE: on the first cycle stable {A,B,C} != 000:
//     - rotN90: dir <= dir-1 mod 4; go to FRAME.
//     - rot90: dir <= dir+1 mod 4; go to FRAME.
//     - fwd: compute target from dir. If out of bounds (x-1 at 0, x+1 at MAP_W-1, etc.): pulse blocked, go to RELEASE. Else latch target into chk_x/chk_y, go to CHECK.
//     - multi: go to RELEASE.
//   - CHECK: chk_req held high with chk_x/chk_y stable until a cycle with chk_ack=1.
//     - chk_wall=1: pulse blocked, go to RELEASE.
//     - chk_wall=0: pos <= target, go to FRAME.
//   - FRAME: frame_req held high until frame_ack=1, then go to RELEASE.
//   - RELEASE: wait for stable {A,B,C} == 000, then go to IDLE.
//  Timing and handshake rules:
//   - pos/dir update on the clock edge that leaves IDLE or CHECK. Requests assert the following cycle.
//   - chk_ack/frame_ack are ignored while the matching req is low.
//   - An ack in the first req-high cycle is legal.
//   - Button changes during CHECK/FRAME are ignored. A held button never repeats (see CONFIGURATION).
//   - dir arithmetic wraps mod 4. pos never leaves 0..MAP_W-1 / 0..MAP_H-1.
// CONFIGURATION
//  MOVE_REPEAT_EN defined:
//   - In RELEASE, if stable input stays 010 for REPEAT_CYCLES, re-run the fwd branch of IDLE.
//   - The counter restarts on each entry to RELEASE.
//  MOVE_REPEAT_EN undefined: no repeat counter; a release is always required.
// STRUCTURE
//  Package doom_pkg:
//   - dir_t (N, E, S, W), move state enum (IDLE, CHECK, FRAME, RELEASE).
//   - Per-direction dx/dy constants, COORD_W default.
//  Sub-module btn_debounce (synchronizer + counter, parameter DEBOUNCE_CYCLES), instantiated 3x.
//  Decode, FSM and position registers live in player_move_ctrl.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
//  1. Reset -> pos=(1,1), dir=0, chk_req=frame_req=blocked=busy=0.
//  2. C held 20 cycles -> dir=1 once, frame_req until ack; release then C again -> dir=2; A -> dir=1.
//  3. dir=1, B -> chk_x=2, chk_y=1, chk_req=1; ack after 3 cycles with wall=0 -> pos=(2,1), frame_req=1.
//  4. Same as 3 with wall=1 -> pos stays (1,1), blocked pulses once, frame_req stays 0.
//  5. pos x=0, dir=3, B -> no chk_req, blocked pulse. A+B together -> no action, busy until both released.
//  6. 2-cycle glitch on B -> no effect. rst asserted during CHECK -> chk_req=0 immediately, pos=(1,1).
//     With MOVE_REPEAT_EN: B held -> repeated steps every REPEAT_CYCLES.

Source files
------------

// File: rtl/doom_pkg.sv
// Shared types and constants for the player movement controller:
// heading and FSM state enums, per-heading step vectors, button decode codes.
package doom_pkg;

    localparam int COORD_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        FRAME   = 2'd2,
        RELEASE = 2'd3
    } move_state_t;

    // Step vectors indexed by heading: N=(0,-1) E=(+1,0) S=(0,+1) W=(-1,0)
    localparam logic signed [1:0] DX [4] = '{2'sd0, 2'sd1, 2'sd0, -2'sd1};
    localparam logic signed [1:0] DY [4] = '{-2'sd1, 2'sd0, 2'sd1, 2'sd0};

    // Stable button patterns as {A,B,C}
    localparam logic [2:0] BTN_NONE    = 3'b000;
    localparam logic [2:0] BTN_ROT_N90 = 3'b100;
    localparam logic [2:0] BTN_FWD     = 3'b010;
    localparam logic [2:0] BTN_ROT_90  = 3'b001;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a stability counter;
// the output level follows the input only after DEBOUNCE_CYCLES steady cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == stable) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Turns debounced A/B/C presses into rotate/forward moves with map wall check
// and frame redraw handshakes. Optional forward auto-repeat: MOVE_REPEAT_EN.
module player_move_ctrl
    import doom_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COORD_W         = COORD_W_DEFAULT,
    parameter int MAP_W           = 16,
    parameter int MAP_H           = 16,
    parameter int START_X         = 1,
    parameter int START_Y         = 1,
    parameter int START_DIR       = 0
`ifdef MOVE_REPEAT_EN
    , parameter int REPEAT_CYCLES = 2000000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               A,
    input  logic               B,
    input  logic               C,
    output logic [COORD_W-1:0] chk_x,
    output logic [COORD_W-1:0] chk_y,
    output logic               chk_req,
    input  logic               chk_ack,
    input  logic               chk_wall,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [1:0]         dir,
    output logic               frame_req,
    input  logic               frame_ack,
    output logic               blocked,
    output logic               busy
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_H - 1);

    logic [2:0] raw_btns;
    logic [2:0] btns;

    assign raw_btns = {A, B, C};

    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_btns[i]),
            .stable (btns[i])
        );
    end

    move_state_t        state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [COORD_W-1:0] chk_x_q, chk_x_d, chk_y_q, chk_y_d;
    logic [COORD_W-1:0] tgt_x, tgt_y;
    logic               blocked_q, blocked_d;
    logic               fwd_out, fwd_go;

    // Edge of the map in the current heading; the step is refused there.
    always_comb begin
        case (dir_q)
            DIR_N:   fwd_out = (pos_y_q == '0);
            DIR_E:   fwd_out = (pos_x_q == X_MAX);
            DIR_S:   fwd_out = (pos_y_q == Y_MAX);
            default: fwd_out = (pos_x_q == '0);
        endcase
    end

    assign tgt_x = pos_x_q + COORD_W'(DX[dir_q]);
    assign tgt_y = pos_y_q + COORD_W'(DY[dir_q]);

`ifdef MOVE_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        chk_x_d   = chk_x_q;
        chk_y_d   = chk_y_q;
        blocked_d = 1'b0;
        fwd_go    = 1'b0;
`ifdef MOVE_REPEAT_EN
        rpt_cnt_d = '0;
`endif
        case (state_q)
            IDLE: begin
                case (btns)
                    BTN_NONE: ;
                    BTN_ROT_N90: begin
                        dir_d   = dir_t'(dir_q - 2'd1);
                        state_d = FRAME;
                    end
                    BTN_ROT_90: begin
                        dir_d   = dir_t'(dir_q + 2'd1);
                        state_d = FRAME;
                    end
                    BTN_FWD: fwd_go = 1'b1;
                    default: state_d = RELEASE;
                endcase
            end
            CHECK: begin
                if (chk_ack) begin
                    if (chk_wall) begin
                        blocked_d = 1'b1;
                        state_d   = RELEASE;
                    end else begin
                        pos_x_d = chk_x_q;
                        pos_y_d = chk_y_q;
                        state_d = FRAME;
                    end
                end
            end
            FRAME: begin
                if (frame_ack) state_d = RELEASE;
            end
            default: begin
                if (btns == BTN_NONE) begin
                    state_d = IDLE;
`ifdef MOVE_REPEAT_EN
                end else if (btns == BTN_FWD) begin
                    if (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1)) fwd_go = 1'b1;
                    else rpt_cnt_d = rpt_cnt_q + 1'b1;
`endif
                end
            end
        endcase

        // Shared forward branch: from IDLE, or from RELEASE on auto-repeat.
        if (fwd_go) begin
            if (fwd_out) begin
                blocked_d = 1'b1;
                state_d   = RELEASE;
            end else begin
                chk_x_d = tgt_x;
                chk_y_d = tgt_y;
                state_d = CHECK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dir_q     <= dir_t'(START_DIR[1:0]);
            pos_x_q   <= COORD_W'(START_X);
            pos_y_q   <= COORD_W'(START_Y);
            chk_x_q   <= '0;
            chk_y_q   <= '0;
            blocked_q <= 1'b0;
`ifdef MOVE_REPEAT_EN
            rpt_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            chk_x_q   <= chk_x_d;
            chk_y_q   <= chk_y_d;
            blocked_q <= blocked_d;
`ifdef MOVE_REPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
`endif
        end
    end

    assign chk_x     = chk_x_q;
    assign chk_y     = chk_y_q;
    assign chk_req   = (state_q == CHECK);
    assign frame_req = (state_q == FRAME);
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign dir       = dir_q;
    assign blocked   = blocked_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a scoreboard of expected position/heading
// popped on each frame request or blocked pulse.
module tb_player_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       A, B, C;
    logic       chk_ack, chk_wall, frame_ack;
    logic [3:0] chk_x, chk_y, pos_x, pos_y;
    logic [1:0] dir;
    logic       chk_req, frame_req, blocked, busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    player_move_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .COORD_W        (4),
        .MAP_W          (16),
        .MAP_H          (16),
        .START_X        (1),
        .START_Y        (1),
        .START_DIR      (0)
`ifdef MOVE_REPEAT_EN
        , .REPEAT_CYCLES(16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .C         (C),
        .chk_x     (chk_x),
        .chk_y     (chk_y),
        .chk_req   (chk_req),
        .chk_ack   (chk_ack),
        .chk_wall  (chk_wall),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .dir       (dir),
        .frame_req (frame_req),
        .frame_ack (frame_ack),
        .blocked   (blocked),
        .busy      (busy)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_btns(input logic [2:0] v);
        {A, B, C} = v;
    endtask

    task automatic push_exp(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
        exp_t e;
        e.x = x; e.y = y; e.d = d;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pos_x"}, 32'(pos_x), 32'(e.x));
            check({tag, "_pos_y"}, 32'(pos_y), 32'(e.y));
            check({tag, "_dir"},   32'(dir),   32'(e.d));
        end
    endtask

    // sel: 0 chk_req, 1 frame_req, 2 idle (busy low), 3 busy
    task automatic wait_sig(input string tag, input int sel, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            case (sel)
                0: hit = chk_req;
                1: hit = frame_req;
                2: hit = !busy;
                default: hit = busy;
            endcase
        end
        if (!hit) begin
            case (sel)
                0: check({tag, "_timeout"}, 32'(chk_req), 1);
                1: check({tag, "_timeout"}, 32'(frame_req), 1);
                2: check({tag, "_timeout"}, 32'(busy), 0);
                default: check({tag, "_timeout"}, 32'(busy), 1);
            endcase
        end
    endtask

    task automatic frame_done(input string tag, input int hold);
        wait_sig({tag, "_wait_frame"}, 1, 40);
        sb_pop(tag);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_frame_held"}, 32'(frame_req), 1);
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check({tag, "_frame_dropped"}, 32'(frame_req), 0);
    endtask

    task automatic watch(input int n, output int n_chk, output int n_frm, output int n_blk);
        n_chk = 0; n_frm = 0; n_blk = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_ack   = 1'b0;
            frame_ack = 1'b0;
            if (chk_req)   n_chk++;
            if (frame_req) n_frm++;
            if (blocked) begin
                n_blk++;
                sb_pop("blocked");
            end
        end
    endtask

    task automatic release_all(input string tag);
        set_btns(3'b000);
        wait_sig({tag, "_idle"}, 2, 40);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int n_chk, n_frm, n_blk;
        rst = 1'b1;
        set_btns(3'b000);
        chk_ack = 1'b0; chk_wall = 1'b0; frame_ack = 1'b0;
        do_reset();

        // Reset state
        check("rst_pos_x", 32'(pos_x), 1);
        check("rst_pos_y", 32'(pos_y), 1);
        check("rst_dir", 32'(dir), 0);
        check("rst_chk_req", 32'(chk_req), 0);
        check("rst_frame_req", 32'(frame_req), 0);
        check("rst_blocked", 32'(blocked), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_chk_xy", 32'({chk_x, chk_y}), 0);

        // C held 20 cycles: exactly one rotation
        set_btns(3'b001);
        push_exp(1, 1, 1);
        frame_done("rot_c1", 3);
        tick(12);
        check("c_held_dir", 32'(dir), 1);
        check("c_held_busy", 32'(busy), 1);
        release_all("c1");
        set_btns(3'b001);
        push_exp(1, 1, 2);
        frame_done("rot_c2", 0);
        release_all("c2");
        set_btns(3'b100);
        push_exp(1, 1, 1);
        frame_done("rot_a", 1);
        release_all("a1");

        // Forward east into open cell
        set_btns(3'b010);
        wait_sig("fwd_wait_chk", 0, 40);
        check("fwd_chk_x", 32'(chk_x), 2);
        check("fwd_chk_y", 32'(chk_y), 1);
        check("fwd_pos_before", 32'(pos_x), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fwd_chk_held", 32'(chk_req), 1);
            check("fwd_chk_x_stable", 32'(chk_x), 2);
        end
        push_exp(2, 1, 1);
        chk_wall = 1'b0;
        chk_ack  = 1'b1;
        tick();
        chk_ack  = 1'b0;
        check("fwd_chk_dropped", 32'(chk_req), 0);
        frame_done("fwd_open", 0);
        release_all("fwd1");

        // Forward east into a wall
        do_reset();
        set_btns(3'b001);
        push_exp(1, 1, 1);
        frame_done("rot_w", 0);
        release_all("rot_w");
        set_btns(3'b010);
        wait_sig("wall_wait_chk", 0, 40);
        check("wall_chk_x", 32'(chk_x), 2);
        push_exp(1, 1, 1);
        chk_wall = 1'b1;
        chk_ack  = 1'b1;
        set_btns(3'b000);
        watch(10, n_chk, n_frm, n_blk);
        check("wall_blocked_cnt", 32'(n_blk), 1);
        check("wall_frame_cnt", 32'(n_frm), 0);
        check("wall_pos_x", 32'(pos_x), 1);
        chk_wall = 1'b0;
        wait_sig("wall_idle", 2, 40);

        // Walk to x=0 facing west, then step off the edge
        do_reset();
        set_btns(3'b100);
        push_exp(1, 1, 3);
        frame_done("rot_west", 0);
        release_all("rot_west");
        set_btns(3'b010);
        wait_sig("west_wait_chk", 0, 40);
        check("west_chk_x", 32'(chk_x), 0);
        push_exp(0, 1, 3);
        chk_ack = 1'b1;
        tick();
        chk_ack = 1'b0;
        frame_done("west_step", 0);
        release_all("west_step");
        set_btns(3'b010);
        push_exp(0, 1, 3);
        watch(12, n_chk, n_frm, n_blk);
        check("edge_chk_cnt", 32'(n_chk), 0);
        check("edge_blocked_cnt", 32'(n_blk), 1);
        release_all("edge");

        // A+B together: a press with no action
        set_btns(3'b110);
        wait_sig("multi_busy", 3, 40);
        watch(12, n_chk, n_frm, n_blk);
        check("multi_chk_cnt", 32'(n_chk), 0);
        check("multi_frame_cnt", 32'(n_frm), 0);
        check("multi_blocked_cnt", 32'(n_blk), 0);
        check("multi_pos_x", 32'(pos_x), 0);
        check("multi_dir", 32'(dir), 3);
        set_btns(3'b010);
        tick(8);
        check("multi_half_busy", 32'(busy), 1);
        release_all("multi");

        // 2-cycle glitch on B
        set_btns(3'b010);
        tick(2);
        set_btns(3'b000);
        watch(15, n_chk, n_frm, n_blk);
        check("glitch_chk_cnt", 32'(n_chk), 0);
        check("glitch_busy", 32'(busy), 0);

        // Reset during CHECK drops the request at once
        set_btns(3'b001);
        push_exp(0, 1, 0);
        frame_done("rot_north", 0);
        release_all("rot_north");
        set_btns(3'b010);
        wait_sig("rstchk_wait", 0, 40);
        check("rstchk_chk_y", 32'(chk_y), 0);
        rst = 1'b1;
        #1;
        check("rstchk_chk_req", 32'(chk_req), 0);
        check("rstchk_pos_x", 32'(pos_x), 1);
        check("rstchk_pos_y", 32'(pos_y), 1);
        check("rstchk_busy", 32'(busy), 0);
        set_btns(3'b000);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("rstchk_after_busy", 32'(busy), 0);

`ifdef MOVE_REPEAT_EN
        // Held B auto-repeats forward steps
        set_btns(3'b001);
        push_exp(1, 1, 1);
        frame_done("rpt_rot", 0);
        release_all("rpt_rot");
        set_btns(3'b010);
        for (int k = 0; k < 3; k++) begin
            wait_sig("rpt_wait_chk", 0, 60);
            check("rpt_chk_x", 32'(chk_x), 32'(2 + k));
            push_exp(4'(2 + k), 1, 1);
            chk_ack = 1'b1;
            tick();
            chk_ack = 1'b0;
            frame_done("rpt_step", 0);
        end
        release_all("rpt");
`endif

        check("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
